// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pci_pkg
//  Purpose  : Shared PCI initiator/arbiter definitions: FSM state encoding,
//             active-low drive levels, default timeouts, burst-count helper.
//  Revision : 1.0  initial release
// ============================================================================
package pci_pkg;

  // Initiator FSM encoding, shared with the arbiter for bus monitoring.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ         = 3'd1,
    ST_ADDR        = 3'd2,
    ST_WAIT_DEVSEL = 3'd3,
    ST_DATA        = 3'd4,
    ST_TURN        = 3'd5
  } pci_state_t;

  // PCI control lines are active-low.
  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  // Default master-side timeouts, in clock cycles.
  localparam int DEF_DEVSEL_TO = 5;
  localparam int DEF_TRDY_TO   = 8;

  // Width of the shared wait counter; large enough for both timeouts.
  localparam int CNT_W = 4;

  // Requested burst length -> legal length: 0 means 1, above the limit clamps.
  function automatic logic [3:0] clamp_words(input logic [3:0] n,
                                             input int unsigned max_words);
    logic [3:0] lim;
    lim = 4'(max_words);
    if (n == 4'd0)
      return 4'd1;
    else if (n > lim)
      return lim;
    else
      return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pci_timeout_cnt
//  Purpose  : Loadable saturating up-counter with synchronous clear, used for
//             the DEVSEL and TRDY wait timeouts of the PCI initiator.
//  Revision : 1.0  initial release
// ============================================================================
module pci_timeout_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Clear has priority over load; counting stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != CNT_MAX))
      count <= count + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/pci_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : pci_master_if
//  Purpose  : PCI initiator interface for one arbitrated device: request/grant
//             handshake, address phase, burst data phases with TRDY# waits,
//             and DEVSEL#/TRDY# master-side timeouts. All outputs registered.
//  Revision : 1.0  initial release
// ============================================================================
module pci_master_if
  import pci_pkg::*;
#(
  parameter int DEV_ID    = 0,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 8,
  parameter int DEVSEL_TO = DEF_DEVSEL_TO,
  parameter int TRDY_TO   = DEF_TRDY_TO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] addr,
  input  logic [3:0]        num_words,
  input  logic [DATA_W-1:0] wdata,
  input  logic              _gnt,
  input  logic              _frame_bus,
  input  logic              _IRDY_bus,
  input  logic              _TRDY,
  input  logic              _DEVSEL,
  output logic              _req,
  output logic              _frame,
  output logic              _IRDY,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              word_ack,
  output logic              done,
  output logic              abort
);

  // Parameter sanity checks at elaboration.
  if (DEV_ID < 0 || DEV_ID > 2) begin : g_bad_dev_id
    $error("pci_master_if: DEV_ID must be 0..2");
  end
  if (MAX_WORDS < 1 || MAX_WORDS > 15) begin : g_bad_max_words
    $error("pci_master_if: MAX_WORDS must be 1..15");
  end
  if (DEVSEL_TO < 1 || DEVSEL_TO > 15 || TRDY_TO < 1 || TRDY_TO > 15) begin : g_bad_timeout
    $error("pci_master_if: timeouts must be 1..15");
  end

  // The counter holds the number of expired wait cycles; the limit is the
  // value seen on the final allowed wait cycle.
  localparam logic [CNT_W-1:0] DEVSEL_LIMIT = CNT_W'(DEVSEL_TO - 1);
  localparam logic [CNT_W-1:0] TRDY_LIMIT   = CNT_W'(TRDY_TO - 1);

  pci_state_t        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [3:0]        rem_q, rem_d;
  logic              gap_q, gap_d;

  logic              req_d, frame_d, irdy_d, ad_oe_d;
  logic [DATA_W-1:0] ad_out_d;
  logic              ack_d, done_d, abort_d;

  logic              go_turn;
  logic              cnt_clr, cnt_en;
  logic [CNT_W-1:0]  cnt;

  // One wait counter serves both the DEVSEL# and TRDY# timeouts, since the
  // two waits never overlap.
  pci_timeout_cnt #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (cnt_en),
    .count    (cnt)
  );

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    req_d    = _req;
    frame_d  = _frame;
    irdy_d   = _IRDY;
    ad_out_d = ad_out;
    ad_oe_d  = ad_oe;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    go_turn  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_d    = DEASSERT_N;
        frame_d  = DEASSERT_N;
        irdy_d   = DEASSERT_N;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        gap_d    = 1'b0;
        if (start) begin
          addr_d  = addr;
          rem_d   = clamp_words(num_words, MAX_WORDS);
          req_d   = ASSERT_N;
          state_d = ST_REQ;
        end
      end

      // Wait indefinitely for grant; only start the address phase on an idle bus.
      ST_REQ: begin
        if (_gnt == ASSERT_N && _frame_bus == DEASSERT_N && _IRDY_bus == DEASSERT_N) begin
          frame_d  = ASSERT_N;
          ad_oe_d  = 1'b1;
          ad_out_d = addr_q;
          state_d  = ST_ADDR;
        end
      end

      // A single-word transaction presents its only word as the final phase,
      // so FRAME# and REQ# drop together with IRDY# asserting.
      ST_ADDR: begin
        req_d    = (rem_q == 4'd1) ? DEASSERT_N : ASSERT_N;
        frame_d  = (rem_q == 4'd1) ? DEASSERT_N : ASSERT_N;
        irdy_d   = ASSERT_N;
        ad_out_d = wdata;
        cnt_clr  = 1'b1;
        state_d  = ST_WAIT_DEVSEL;
      end

      ST_WAIT_DEVSEL: begin
        if (_DEVSEL == ASSERT_N) begin
          cnt_clr = 1'b1;
          state_d = ST_DATA;
        end else if (cnt == DEVSEL_LIMIT) begin
          abort_d = 1'b1;
          go_turn = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_DATA: begin
        if (gap_q) begin
          // Reload cycle: the source has advanced wdata after word_ack, so
          // present the fresh word and reassert IRDY#.
          gap_d    = 1'b0;
          irdy_d   = ASSERT_N;
          ad_out_d = wdata;
          cnt_clr  = 1'b1;
          if (rem_q == 4'd1) begin
            frame_d = DEASSERT_N;
            req_d   = DEASSERT_N;
          end
        end else if (_IRDY == ASSERT_N && _TRDY == ASSERT_N) begin
          // Completion is checked before the timeout, so it wins a tie.
          ack_d = 1'b1;
          if (rem_q == 4'd1) begin
            done_d  = 1'b1;
            go_turn = 1'b1;
          end else begin
            rem_d   = rem_q - 4'd1;
            gap_d   = 1'b1;
            irdy_d  = DEASSERT_N;
            cnt_clr = 1'b1;
          end
        end else if (cnt == TRDY_LIMIT) begin
          abort_d = 1'b1;
          go_turn = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_TURN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every path into TURN releases the bus in the same registered update.
    if (go_turn) begin
      req_d    = DEASSERT_N;
      frame_d  = DEASSERT_N;
      irdy_d   = DEASSERT_N;
      ad_oe_d  = 1'b0;
      ad_out_d = '0;
      gap_d    = 1'b0;
      state_d  = ST_TURN;
    end
  end

  // State and registered-output update; reset releases every bus line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      gap_q    <= 1'b0;
      _req     <= DEASSERT_N;
      _frame   <= DEASSERT_N;
      _IRDY    <= DEASSERT_N;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      word_ack <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      _req     <= req_d;
      _frame   <= frame_d;
      _IRDY    <= irdy_d;
      ad_out   <= ad_out_d;
      ad_oe    <= ad_oe_d;
      word_ack <= ack_d;
      done     <= done_d;
      abort    <= abort_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pci_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pci_master_if
//  Purpose  : Directed self-checking bench for pci_master_if.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pci_master_if;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  num_words = '0;
  logic [31:0] wdata = '0;
  logic        gnt_n = 1'b1;
  logic        frame_bus_n = 1'b1;
  logic        irdy_bus_n = 1'b1;
  logic        trdy_n = 1'b1;
  logic        devsel_n = 1'b1;

  logic        req_n, frame_n, irdy_n, ad_oe, word_ack, done, abort;
  logic [31:0] ad_out;

  int errors = 0;
  int checks = 0;
  int n_ack, n_done, n_abort, word_idx;
  logic both_seen = 1'b0;

  pci_master_if #(
    .DEV_ID    (0),
    .DATA_W    (32),
    .MAX_WORDS (8),
    .DEVSEL_TO (5),
    .TRDY_TO   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr       (addr),
    .num_words  (num_words),
    .wdata      (wdata),
    ._gnt       (gnt_n),
    ._frame_bus (frame_bus_n),
    ._IRDY_bus  (irdy_bus_n),
    ._TRDY      (trdy_n),
    ._DEVSEL    (devsel_n),
    ._req       (req_n),
    ._frame     (frame_n),
    ._IRDY      (irdy_n),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .word_ack   (word_ack),
    .done       (done),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  // Advance one clock, sample just after the edge, and act as the data source.
  task automatic tick();
    @(posedge clk);
    #1;
    if (word_ack) begin
      n_ack++;
      word_idx++;
      wdata = word(word_idx);
    end
    if (done)  n_done++;
    if (abort) n_abort++;
    if (done && abort) both_seen = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_txn(input logic [31:0] a, input logic [3:0] n);
    addr      = a;
    num_words = n;
    word_idx  = 0;
    wdata     = word(0);
    n_ack     = 0;
    n_done    = 0;
    n_abort   = 0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    logic finished;
    finished = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (n_done + n_abort > 0) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'd0, finished}, 32'd1);
  endtask

  task automatic go_idle();
    gnt_n = 1'b1; trdy_n = 1'b1; devsel_n = 1'b1;
    frame_bus_n = 1'b1; irdy_bus_n = 1'b1;
    tick(); tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_req",   {31'd0, req_n},   32'd1);
    chk("rst_frame", {31'd0, frame_n}, 32'd1);
    chk("rst_irdy",  {31'd0, irdy_n},  32'd1);
    chk("rst_ad",    ad_out,           32'd0);
    chk("rst_oe",    {31'd0, ad_oe},   32'd0);
    chk("rst_pulses", {29'd0, word_ack, done, abort}, 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- single write ----------------
    begin_txn(32'hA000_0010, 4'd1);
    chk("t1_req", {31'd0, req_n}, 32'd0);
    gnt_n = 1'b0;
    tick();
    chk("t1_addr_frame", {31'd0, frame_n}, 32'd0);
    chk("t1_addr_oe",    {31'd0, ad_oe},   32'd1);
    chk("t1_addr_ad",    ad_out,           32'hA000_0010);
    chk("t1_addr_irdy",  {31'd0, irdy_n},  32'd1);
    devsel_n = 1'b0; trdy_n = 1'b0;
    tick();
    chk("t1_last_irdy",  {31'd0, irdy_n},  32'd0);
    chk("t1_last_frame", {31'd0, frame_n}, 32'd1);
    chk("t1_last_ad",    ad_out,           word(0));
    chk("t1_last_req",   {31'd0, req_n},   32'd1);
    tick();
    chk("t1_no_ack_yet", {31'd0, word_ack}, 32'd0);
    tick();
    chk("t1_ack_done_abort", {29'd0, word_ack, done, abort}, 32'b110);
    chk("t1_release", {29'd0, frame_n, irdy_n, ad_oe}, 32'b110);
    chk("t1_release_ad", ad_out, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_n_ack", 32'(n_ack), 32'd1);
    go_idle();

    // ---------------- burst of 4, TRDY# waits on phase 2 ----------------
    begin_txn(32'hA000_0200, 4'd4);
    gnt_n = 1'b0;
    tick();
    chk("t2_addr_ad", ad_out, 32'hA000_0200);
    gnt_n = 1'b1;          // grant removed after address phase
    devsel_n = 1'b0; trdy_n = 1'b0;
    tick();
    chk("t2_w0", ad_out, word(0));
    chk("t2_w0_ctl", {30'd0, frame_n, req_n}, 32'b00);
    tick();
    tick();
    chk("t2_ack1", 32'(n_ack), 32'd1);
    chk("t2_gap_irdy", {31'd0, irdy_n}, 32'd1);
    tick();
    chk("t2_w1", ad_out, word(1));
    chk("t2_w1_ctl", {30'd0, frame_n, irdy_n}, 32'b00);
    trdy_n = 1'b1;
    tick();
    chk("t2_wait1", {30'd0, irdy_n, word_ack}, 32'b00);
    start = 1'b1; addr = 32'hBAD0_BAD0; num_words = 4'd2;   // ignored: not IDLE
    tick();
    start = 1'b0;
    chk("t2_wait2", {30'd0, irdy_n, word_ack}, 32'b00);
    trdy_n = 1'b0;
    tick();
    chk("t2_ack2", 32'(n_ack), 32'd2);
    tick();
    chk("t2_w2", ad_out, word(2));
    chk("t2_w2_frame", {31'd0, frame_n}, 32'd0);
    tick();
    chk("t2_ack3", 32'(n_ack), 32'd3);
    tick();
    chk("t2_w3", ad_out, word(3));
    chk("t2_w3_ctl", {30'd0, frame_n, irdy_n}, 32'b10);
    tick();
    chk("t2_done", {30'd0, done, abort}, 32'b10);
    chk("t2_n_ack", 32'(n_ack), 32'd4);
    tick(); tick();
    chk("t2_ignored_start", {31'd0, req_n}, 32'd1);
    chk("t2_n_abort", 32'(n_abort), 32'd0);
    go_idle();

    // ---------------- DEVSEL# never asserted -> master abort ----------------
    begin_txn(32'hA000_0300, 4'd2);
    gnt_n = 1'b0;
    tick();
    tick();
    chk("t3_irdy", {31'd0, irdy_n}, 32'd0);
    gnt_n = 1'b1;
    repeat (4) tick();
    chk("t3_no_abort_yet", {31'd0, abort}, 32'd0);
    tick();
    chk("t3_abort", {30'd0, abort, done}, 32'b10);
    chk("t3_release", {30'd0, frame_n, irdy_n}, 32'b11);
    chk("t3_n_ack", 32'(n_ack), 32'd0);
    go_idle();

    // ---------------- TRDY# held off 8 cycles -> abort ----------------
    devsel_n = 1'b0;
    begin_txn(32'hA000_0400, 4'd1);
    gnt_n = 1'b0;
    tick(); tick();
    gnt_n = 1'b1;
    tick();
    repeat (7) tick();
    chk("t4a_no_abort_yet", {31'd0, abort}, 32'd0);
    tick();
    chk("t4a_abort", {30'd0, abort, done}, 32'b10);
    chk("t4a_n_ack", 32'(n_ack), 32'd0);
    go_idle();

    // ---------------- TRDY# on the 8th cycle with the last word -> done ----------------
    devsel_n = 1'b0;
    begin_txn(32'hA000_0500, 4'd1);
    gnt_n = 1'b0;
    tick(); tick();
    gnt_n = 1'b1;
    tick();
    repeat (7) tick();
    trdy_n = 1'b0;
    tick();
    chk("t4b_done_not_abort", {29'd0, word_ack, done, abort}, 32'b110);
    go_idle();

    // ---------------- grant while bus busy ----------------
    frame_bus_n = 1'b0;
    begin_txn(32'hA000_0600, 4'd1);
    gnt_n = 1'b0;
    tick(); tick();
    chk("t5_busy_frame", {30'd0, frame_n, req_n}, 32'b10);
    frame_bus_n = 1'b1; irdy_bus_n = 1'b0;
    tick();
    chk("t5_busy_irdy", {31'd0, frame_n}, 32'd1);
    irdy_bus_n = 1'b1;
    tick();
    chk("t5_addr_frame", {31'd0, frame_n}, 32'd0);
    chk("t5_addr_ad", ad_out, 32'hA000_0600);
    devsel_n = 1'b0; trdy_n = 1'b0;
    wait_end("t5_timeout");
    chk("t5_done", 32'(n_done), 32'd1);
    go_idle();

    // ---------------- reset mid-burst, then clamped burst ----------------
    devsel_n = 1'b0;
    begin_txn(32'hA000_0700, 4'd4);
    gnt_n = 1'b0;
    tick(); tick();
    gnt_n = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_lines", {29'd0, req_n, frame_n, irdy_n}, 32'b111);
    chk("t6_rst_pulses", {28'd0, ad_oe, word_ack, done, abort}, 32'd0);
    chk("t6_rst_ad", ad_out, 32'd0);
    reset = 1'b0;
    tick();
    trdy_n = 1'b0;
    begin_txn(32'hA000_0800, 4'd12);
    gnt_n = 1'b0;
    tick();
    chk("t6_addr_ad", ad_out, 32'hA000_0800);
    gnt_n = 1'b1;
    wait_end("t6_timeout");
    chk("t6_n_ack", 32'(n_ack), 32'd8);
    chk("t6_outcome", {n_done[15:0], n_abort[15:0]}, {16'd1, 16'd0});
    go_idle();

    chk("done_abort_exclusive", {31'd0, both_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pci_master_if.md
Name: pci_master_if

Overview:
Initiator-side PCI bus interface for one device, DEV_ID, that sits directly upstream of the round-robin bus arbiter. It drives this device's request line into the arbiter and waits for the device's grant. Once granted, it runs the FRAME#/IRDY# transaction protocol the arbiter monitors: address phase, N data phases with TRDY# wait states, then release. It also enforces the master-side timeouts, so a granted device never hangs the bus.

Parameters:
DEV_ID, 0, arbiter request/grant index of this device (0..2)
DATA_W, 32, width of address/data path
MAX_WORDS, 8, maximum data phases per transaction (burst limit)
DEVSEL_TO, 5, cycles after address phase to wait for _DEVSEL before master abort
TRDY_TO, 8, cycles in a data phase without _TRDY before abort (matches arbiter 8-cycle rule)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse: begin transaction (ignored unless IDLE)
addr  input  DATA_W  transaction address, captured on start
num_words  input  4  data phases requested, captured on start; 0 treated as 1, >MAX_WORDS clamped
wdata  input  DATA_W  write data for current phase (held by source until word_ack)
_gnt  input  1  this device's grant from arbiter, active-low
_frame_bus  input  1  sampled bus FRAME#, active-low
_IRDY_bus  input  1  sampled bus IRDY#, active-low
_TRDY  input  1  target ready, active-low
_DEVSEL  input  1  target claim, active-low
_req  output  1  bus request to arbiter, active-low
_frame  output  1  FRAME# drive, active-low
_IRDY  output  1  IRDY# drive, active-low
ad_out  output  DATA_W  address in ADDR phase, wdata in DATA phase, 0 otherwise
ad_oe  output  1  high while ad_out is driven
word_ack  output  1  one-cycle pulse per completed data phase
done  output  1  one-cycle pulse: transaction completed normally
abort  output  1  one-cycle pulse: transaction aborted (timeout)

Behaviour:
- Reset: state IDLE. _req=_frame=_IRDY=1; ad_out=0; ad_oe=word_ack=done=abort=0; counters cleared. Reset mid-transaction releases all bus lines on the next edge.
- All outputs are registered. FSM states: IDLE, REQ, ADDR, WAIT_DEVSEL, DATA, TURN.
- IDLE: start=1 captures addr and the clamped count into remaining, then goes to REQ with _req=0 next cycle.
- REQ: _req held 0. When _gnt=0 and the bus is idle (_frame_bus=1 and _IRDY_bus=1), go to ADDR: _frame=0, ad_oe=1, ad_out=addr. While _gnt=1, stay in REQ with no timeout.
- ADDR (1 cycle): _req returns to 1 if remaining==1, otherwise stays 0. Next state is WAIT_DEVSEL with _IRDY=0 and ad_out=wdata.
- WAIT_DEVSEL: a cycle counter starts at 0.
  - _DEVSEL=0 goes to DATA.
  - If the counter reaches DEVSEL_TO, it is a master abort: abort pulse, go to TURN.
- DATA:
  - A phase completes on a cycle where _IRDY=0 and _TRDY=0. That cycle pulses word_ack and decrements remaining.
  - When remaining==1, _frame is deasserted (1) in the same registered update that presents the last word. FRAME# is always high during the final phase, IRDY# low.
  - After the final phase completes: done pulse, go to TURN.
  - The wait counter resets on each completed phase. TRDY_TO consecutive cycles with _TRDY=1 raise abort and go to TURN.
- TURN (1 cycle): _frame=_IRDY=1, ad_oe=0, then IDLE. New start is accepted from IDLE only.
- Grant lost in REQ before ADDR: stay in REQ. Grant removed after ADDR: the transaction continues to completion (PCI rule). The arbiter's 16-cycle FRAME# rule is met because ADDR follows an idle bus within 1 cycle of grant.
- Simultaneous final word_ack and TRDY_TO reached: completion wins (done, not abort). done and abort are never both 1.
- start while not IDLE is ignored, with no error.

Decomposition:
- Shared package pci_pkg holds the FSM state encoding, the active-low ASSERT/DEASSERT constants, and default DEVSEL_TO/TRDY_TO. The arbiter reuses these.
- One natural sub-module, pci_timeout_cnt: a loadable saturating counter with clear, instantiated once and shared by the DEVSEL and TRDY waits.

Test Plan:
- Single write, num_words=1, _gnt=0 one cycle after _req=0, _DEVSEL=0 and _TRDY=0 immediately -> ADDR with ad_out=addr, then one data phase with _frame=1 and _IRDY=0, word_ack and done once, bus released, back in IDLE within 5 cycles of grant.
- Burst num_words=4, _TRDY high for 2 cycles on phase 2 -> 4 word_ack pulses, _IRDY stays 0 through the waits, _frame rises exactly on phase 4, done=1, abort never.
- _DEVSEL held 1 -> abort exactly DEVSEL_TO=5 cycles after ADDR, _frame/_IRDY return to 1, no word_ack.
- _TRDY held 1 for 8 cycles in DATA -> abort, TURN, IDLE. Also _TRDY asserted on cycle 8 together with the last word -> done, not abort.
- Grant arrives while _frame_bus=0 (bus busy) -> stays in REQ. ADDR occurs on the first cycle the bus is idle.
- reset=1 during DATA of a 4-word burst -> next edge all active-low outputs are 1, done/abort are 0, state is IDLE, and a new start works normally. num_words=12 -> exactly 8 phases.
